// File: rtl/uart_cmd_responder.sv
`default_nettype none
// ============================================================================
// Module   : uart_cmd_responder
// Function : UART byte-stream command parser driving single-byte reads and
//            writes on a 16-bit address memory bus, with one reply per frame.
// Revision : 1.0  initial release
// ============================================================================
module uart_cmd_responder #(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd5_000_000,
    parameter logic [7:0]  ACK_BYTE       = 8'h4B,
    parameter logic [7:0]  NAK_BYTE       = 8'h3F
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_byte,
    input  logic        rx_error,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    input  logic        tx_busy,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    input  logic [7:0]  mem_rdata,
    output logic        busy,
    output logic        frame_error
);

    localparam logic [7:0] C_OP_WRITE = 8'h57;
    localparam logic [7:0] C_OP_READ  = 8'h52;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ADDR_HI = 3'd1,
        S_ADDR_LO = 3'd2,
        S_WDATA   = 3'd3,
        S_MEM_RD  = 3'd4,
        S_MEM_CAP = 3'd5,
        S_TX_REQ  = 3'd6,
        S_TX_WAIT = 3'd7
    } state_t;

    state_t      r_state, w_state_next;
    logic [23:0] r_timer, w_timer_next;
    logic        r_is_write, w_is_write_next;
    logic        r_tx_first, w_tx_first_next;
    logic        r_tx_start, w_tx_start_next;
    logic [7:0]  r_tx_data, w_tx_data_next;
    logic [15:0] r_mem_addr, w_mem_addr_next;
    logic [7:0]  r_mem_wdata, w_mem_wdata_next;
    logic        r_mem_we, w_mem_we_next;
    logic        r_mem_re, w_mem_re_next;
    logic        r_frame_error, w_frame_error_next;
    logic        w_timeout;

    assign w_timeout = (r_timer == (TIMEOUT_CYCLES - 24'd1));

    always_comb begin
        w_state_next       = r_state;
        w_timer_next       = '0;
        w_is_write_next    = r_is_write;
        w_tx_first_next    = r_tx_first;
        w_tx_start_next    = 1'b0;
        w_tx_data_next     = r_tx_data;
        w_mem_addr_next    = r_mem_addr;
        w_mem_wdata_next   = r_mem_wdata;
        w_mem_we_next      = 1'b0;
        w_mem_re_next      = 1'b0;
        w_frame_error_next = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (rx_valid) begin
                    if (rx_byte == C_OP_WRITE || rx_byte == C_OP_READ) begin
                        w_is_write_next = (rx_byte == C_OP_WRITE);
                        w_state_next    = S_ADDR_HI;
                    end else begin
                        w_tx_data_next = NAK_BYTE;
                        w_state_next   = S_TX_REQ;
                    end
                end
            end

            S_ADDR_HI, S_ADDR_LO, S_WDATA: begin
                // Priority: receiver error, then a new byte, then expiry.
                if (rx_error) begin
                    w_frame_error_next = 1'b1;
                    w_state_next       = S_IDLE;
                end else if (rx_valid) begin
                    if (r_state == S_ADDR_HI) begin
                        w_mem_addr_next[15:8] = rx_byte;
                        w_state_next          = S_ADDR_LO;
                    end else if (r_state == S_ADDR_LO) begin
                        w_mem_addr_next[7:0] = rx_byte;
                        w_state_next         = r_is_write ? S_WDATA : S_MEM_RD;
                        w_mem_re_next        = !r_is_write;
                    end else begin
                        w_mem_wdata_next = rx_byte;
                        w_mem_we_next    = 1'b1;
                        w_tx_data_next   = ACK_BYTE;
                        w_state_next     = S_TX_REQ;
                    end
                end else if (w_timeout) begin
                    w_frame_error_next = 1'b1;
                    w_state_next       = S_IDLE;
                end else begin
                    w_timer_next = r_timer + 24'd1;
                end
            end

            S_MEM_RD: begin
                w_state_next = S_MEM_CAP;
            end

            S_MEM_CAP: begin
                w_tx_data_next = mem_rdata;
                w_state_next   = S_TX_REQ;
            end

            S_TX_REQ: begin
                if (!tx_busy) begin
                    w_tx_start_next = 1'b1;
                    w_tx_first_next = 1'b1;
                    w_state_next    = S_TX_WAIT;
                end
            end

            S_TX_WAIT: begin
                // The transmitter raises busy one cycle after tx_start.
                if (r_tx_first) begin
                    w_tx_first_next = 1'b0;
                end else if (!tx_busy) begin
                    w_state_next = S_IDLE;
                end
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_timer       <= '0;
            r_is_write    <= 1'b0;
            r_tx_first    <= 1'b0;
            r_tx_start    <= 1'b0;
            r_tx_data     <= '0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_mem_we      <= 1'b0;
            r_mem_re      <= 1'b0;
            r_frame_error <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_timer       <= w_timer_next;
            r_is_write    <= w_is_write_next;
            r_tx_first    <= w_tx_first_next;
            r_tx_start    <= w_tx_start_next;
            r_tx_data     <= w_tx_data_next;
            r_mem_addr    <= w_mem_addr_next;
            r_mem_wdata   <= w_mem_wdata_next;
            r_mem_we      <= w_mem_we_next;
            r_mem_re      <= w_mem_re_next;
            r_frame_error <= w_frame_error_next;
        end
    end

    assign tx_start    = r_tx_start;
    assign tx_data     = r_tx_data;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign mem_we      = r_mem_we;
    assign mem_re      = r_mem_re;
    assign frame_error = r_frame_error;
    assign busy        = (r_state != S_IDLE);

endmodule
`default_nettype wire
